// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
// Optional stats build: define FIFO_READER_STATS_EN.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } fifo_reader_state_t;

  function automatic int skid_depth(input int read_latency);
    return read_latency + 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular store absorbing FIFO read latency.
// Head entry is registered and drives the stream data.
module stream_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CW-1:0]         count_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**PW];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  wr_ok;
  logic                  rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_ok   = rd_i && (cnt_q != '0);
  assign wr_ok   = wr_i && ((cnt_q != CW'(DEPTH)) || rd_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Pointer/count bookkeeping; a flush empties the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**PW; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for basic_sync_fifo, re-framed as a valid/ready burst stream.
// Optional stats counters: define FIFO_READER_STATS_EN.
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int BURST_LEN    = 16,
  parameter int STATS_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   flush,
  output logic                   fifo_shift_out,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_valid,
  input  logic                   fifo_empty,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   protocol_err,
  output logic [STATS_WIDTH-1:0] beat_count,
  output logic [STATS_WIDTH-1:0] stall_count
);

  localparam int SKID_DEPTH = skid_depth(READ_LATENCY);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_lat
    $error("READ_LATENCY must be 0 or 1");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must be >= 1");
  end

  fifo_reader_state_t state_q;
  logic [CW-1:0]      cnt;
  logic [2:0]         occ;
  logic               out_fire;
  logic               inflight;
  logic               pop_pending;
  logic               capture;
  logic [BW-1:0]      beat_q;
  logic               perr_q;

  assign m_valid  = (cnt != '0) && (state_q != FLUSH);
  assign out_fire = m_valid && m_ready;
  assign occ      = 3'(cnt) + 3'(inflight) - 3'(out_fire);

  assign fifo_shift_out = (state_q == STREAM) && !flush
                       && !fifo_empty && (occ < 3'(SKID_DEPTH));

  assign capture = fifo_valid && (state_q != FLUSH) && !flush;

  if (READ_LATENCY == 1) begin : g_lat1
    logic inflight_q;
    // A pop issued this cycle returns data next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_q <= 1'b0;
      else        inflight_q <= fifo_shift_out;
    end
    assign inflight    = inflight_q;
    assign pop_pending = inflight_q;
  end else begin : g_lat0
    assign inflight    = 1'b0;
    assign pop_pending = fifo_shift_out;
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (flush),
    .wr_i     (capture),
    .wr_data_i(fifo_dout),
    .rd_i     (out_fire),
    .head_o   (m_data),
    .count_o  (cnt)
  );

  // Control FSM; flush overrides every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (enable) state_q <= STREAM;
        STREAM:  if (!enable) state_q <= IDLE;
        FLUSH:   if (!inflight) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat position within the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        beat_q <= '0;
    else if (flush)    beat_q <= '0;
    else if (out_fire) beat_q <= (beat_q == BW'(BURST_LEN - 1))
                                 ? '0 : beat_q + 1'b1;
  end

  assign m_last = m_valid && (beat_q == BW'(BURST_LEN - 1));

  // Sticky flag for read data that no pop asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          perr_q <= 1'b0;
    else if (fifo_valid && !pop_pending) perr_q <= 1'b1;
  end

  assign protocol_err = perr_q;

`ifdef FIFO_READER_STATS_EN
  logic [STATS_WIDTH-1:0] beat_cnt_q;
  logic [STATS_WIDTH-1:0] stall_cnt_q;

  // Saturating beat/stall statistics, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_fire && !(&beat_cnt_q))
        beat_cnt_q <= beat_cnt_q + 1'b1;
      if (m_valid && !m_ready && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign beat_count  = beat_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign beat_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader at read latency 0 and 1.
// FIFO word k carries value k; expected beats are queued when popped.
module tb_fifo_stream_reader;

  localparam int BL = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic flush;
  logic mr;
  logic inj;
  int   wr_k = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int l,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lat%0d %s: got %h expected %h", l, nm, act, exp);
    end
  endtask

  for (genvar L = 0; L < 2; L++) begin : g_lat
    logic        so, fv, fv_q, mv, ml, perr;
    logic [31:0] fd, fd_q, md, bc, sc;
    int          rd_k = 0;
    logic [31:0] expq[$];
    int          acc, ebc, esc, fp, ff, lf, nf;
    bit          hold, err_exp, qe;
    logic [31:0] hd;
    logic        hl;

    assign fv = ((L == 1) ? fv_q : so) | inj;
    assign fd = (L == 1) ? fd_q : 32'(rd_k);

    always @(posedge clk) if (so) rd_k <= rd_k + 1;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fv_q <= 1'b0;
        fd_q <= '0;
      end else begin
        fv_q <= so;
        fd_q <= 32'(rd_k);
      end
    end

    fifo_stream_reader #(
      .DATA_WIDTH  (32),
      .READ_LATENCY(L),
      .BURST_LEN   (BL),
      .STATS_WIDTH (32)
    ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .flush         (flush),
      .fifo_shift_out(so),
      .fifo_dout     (fd),
      .fifo_valid    (fv),
      .fifo_empty    (rd_k == wr_k),
      .m_data        (md),
      .m_valid       (mv),
      .m_ready       (mr),
      .m_last        (ml),
      .protocol_err  (perr),
      .beat_count    (bc),
      .stall_count   (sc)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        expq.delete();
        acc = 0; ebc = 0; esc = 0; nf = 0;
        fp = -1; ff = -1; lf = -1;
        hold = 0; err_exp = 0; qe = 1;
      end else begin
        chk("protocol_err", L, 32'(perr), 32'(err_exp));
        if (hold) begin
          chk("hold_valid", L, 32'(mv), 1);
          chk("hold_data", L, md, hd);
          chk("hold_last", L, 32'(ml), 32'(hl));
        end
        if (mv && mr) begin
          if (expq.size() == 0) begin
            chk("extra_beat", L, md, 32'hFFFF_FFFF);
          end else begin
            chk("data", L, md, expq.pop_front());
            chk("last", L, 32'(ml), 32'((acc % BL) == BL - 1));
          end
          acc++; nf++;
          if (ff < 0) ff = cyc;
          lf = cyc;
        end
`ifdef FIFO_READER_STATS_EN
        chk("beat_count", L, bc, 32'(ebc));
        chk("stall_count", L, sc, 32'(esc));
        if (flush) begin
          ebc = 0; esc = 0;
        end else begin
          if (mv && mr) ebc++;
          if (mv && !mr) esc++;
        end
`else
        chk("beat_count", L, bc, 0);
        chk("stall_count", L, sc, 0);
`endif
        hold = mv && !mr && !flush;
        hd = md;
        hl = ml;
        if (flush) begin
          expq.delete();
          acc = 0;
        end
        if (inj) err_exp = 1;
        if (so) begin
          expq.push_back(32'(rd_k));
          if (fp < 0) fp = cyc;
        end
        qe = (expq.size() == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int l, input logic mv, input logic [31:0] md,
                          input logic ml, input logic so, input logic pe);
    chk("rst_valid", l, 32'(mv), 0);
    chk("rst_data", l, md, 0);
    chk("rst_last", l, 32'(ml), 0);
    chk("rst_pop", l, 32'(so), 0);
    chk("rst_perr", l, 32'(pe), 0);
  endtask

  task automatic wait_drain(input string nm);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < 3000) begin
      tick();
      n++;
      if (g_lat[0].rd_k == wr_k && g_lat[1].rd_k == wr_k
          && g_lat[0].qe && g_lat[1].qe)
        stable++;
      else
        stable = 0;
    end
    chk(nm, 0, 32'(stable >= 3), 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; mr = 1'b0; inj = 1'b0;
    repeat (3) tick();
    chk_zero(0, g_lat[0].mv, g_lat[0].md, g_lat[0].ml, g_lat[0].so, g_lat[0].perr);
    chk_zero(1, g_lat[1].mv, g_lat[1].md, g_lat[1].ml, g_lat[1].so, g_lat[1].perr);
    rst_n = 1'b1;
    tick();

    // preloaded 0..19, full rate
    wr_k = 20; enable = 1'b1; mr = 1'b1;
    wait_drain("drain_basic");
    for (int l = 0; l < 2; l++) begin
      int nf, ff, lf, fp;
      nf = (l == 0) ? g_lat[0].nf : g_lat[1].nf;
      ff = (l == 0) ? g_lat[0].ff : g_lat[1].ff;
      lf = (l == 0) ? g_lat[0].lf : g_lat[1].lf;
      fp = (l == 0) ? g_lat[0].fp : g_lat[1].fp;
      chk("beats_basic", l, 32'(nf), 20);
      chk("back_to_back", l, 32'(lf - ff), 19);
      chk("first_latency", l, 32'(ff - fp), 32'(l + 1));
    end

    // random back-pressure, enable toggles, occasional flush
    for (int c = 0; c < 900; c++) begin
      int lo;
      mr = 1'($urandom % 2);
      lo = (g_lat[0].rd_k < g_lat[1].rd_k) ? g_lat[0].rd_k : g_lat[1].rd_k;
      if (wr_k < 220 && wr_k - lo < 6) wr_k += $urandom_range(0, 3);
      if ($urandom % 50 == 0) enable = ~enable;
      flush = ($urandom % 80 == 0);
      tick();
    end
    flush = 1'b0; enable = 1'b1; mr = 1'b1;
    wait_drain("drain_random");

    // flush while a latency-1 pop is in flight
    wr_k += 10;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 0, 32'(g_lat[0].mv), 0);
    chk("flush_valid", 1, 32'(g_lat[1].mv), 0);
    wait_drain("drain_flush");

    // asynchronous reset mid-burst
    wr_k += 30;
    repeat (6) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_zero(0, g_lat[0].mv, g_lat[0].md, g_lat[0].ml, g_lat[0].so, g_lat[0].perr);
    chk_zero(1, g_lat[1].mv, g_lat[1].md, g_lat[1].ml, g_lat[1].so, g_lat[1].perr);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_drain("drain_reset");

    // unsolicited read data
    enable = 1'b0;
    repeat (5) tick();
    inj = 1'b1; flush = 1'b1;
    tick();
    inj = 1'b0; flush = 1'b0;
    repeat (4) tick();
    chk("perr_sticky", 0, 32'(g_lat[0].perr), 1);
    chk("perr_sticky", 1, 32'(g_lat[1].perr), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
